n_bit_counter: RTL and testbench

Free-running binary up-counter with a parameterizable width and an asynchronous active-low clear. Used as the basic event and time-base counter in the ring-oscillator measurement path. One instance counts reference-clock cycles to form a gate window; a second instance, clocked by the ring-oscillator output, counts oscillator edges within that window. Both instances share one clear line driven by the surrounding control logic.

---
 rtl/n_bit_counter.sv | 32 +++
 tb/tb_n_bit_counter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/n_bit_counter.sv
// n_bit_counter: free-running binary up-counter with asynchronous active-low clear.
// Serves as the gate-window and oscillator-edge counter in the ring-oscillator
// measurement path; several instances may share one clear line while running
// from unrelated clocks.
module n_bit_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] count
);

    // Reject widths outside the supported 1..32 range at elaboration time.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("n_bit_counter: WIDTH must be in 1..32");
    end

    logic [WIDTH-1:0] count_q;

    // Count register: cleared immediately by rst_n low, otherwise +1 per rising
    // edge. The add is exactly WIDTH bits, so the carry-out drops and the value wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_n_bit_counter.sv
// tb_n_bit_counter: randomized self-checking bench for n_bit_counter.
// Three instances (WIDTH 16, 4, 8) share a manually driven clock; a fourth
// (WIDTH 16) runs from an independent 3.7 ns clock. All share one rst_n.
// The reference model counts qualifying rising edges since the last reset and
// reduces that count modulo 2^WIDTH.
`timescale 1ns/1ps
module tb_n_bit_counter;

    logic        clk_m;
    logic        clk_b;
    logic        run_b;
    logic        rst_n;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
    logic [7:0]  cnt8;
    logic [15:0] cntb;

    int unsigned n_tests;
    int unsigned n_failed;
    longint unsigned edges;   // rising clk_m edges seen with rst_n high since last clear

    n_bit_counter #(.WIDTH(16)) u_w16 (.clk(clk_m), .rst_n(rst_n), .count(cnt16));
    n_bit_counter #(.WIDTH(4))  u_w4  (.clk(clk_m), .rst_n(rst_n), .count(cnt4));
    n_bit_counter #(.WIDTH(8))  u_w8  (.clk(clk_m), .rst_n(rst_n), .count(cnt8));
    n_bit_counter #(.WIDTH(16)) u_b   (.clk(clk_b), .rst_n(rst_n), .count(cntb));

    // Independent 3.7 ns clock, only toggling while run_b is set.
    always begin
        #1.85;
        if (run_b) clk_b = ~clk_b;
    end

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] model(input int unsigned w);
        return 32'(edges % (64'd1 << w));
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, "_w16"}, 32'(cnt16), model(16));
        check_eq({tag, "_w4"},  32'(cnt4),  model(4));
        check_eq({tag, "_w8"},  32'(cnt8),  model(8));
    endtask

    // n full clk_m periods; ends with clk low, between edges.
    task automatic tick(input int unsigned n, input real half);
        for (int unsigned i = 0; i < n; i++) begin
            clk_m = 1'b1;
            if (rst_n) edges++;
            #(half);
            clk_m = 1'b0;
            #(half);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        edges = 0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int unsigned n;
        int unsigned pw;
        n_tests  = 0;
        n_failed = 0;
        edges    = 0;
        clk_m    = 1'b0;
        clk_b    = 1'b0;
        run_b    = 1'b0;
        rst_n    = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_all("reset_state");
        check_eq("reset_state_b", 32'(cntb), 32'd0);

        // Clock edges while held in reset leave the count at 0.
        tick(5, 1.0);
        check_all("hold_in_reset");

        // Release and count 10 edges; value steady after the falling edge.
        rst_n = 1'b1;
        #1;
        for (int k = 1; k <= 10; k++) begin
            clk_m = 1'b1;
            edges++;
            #1;
            check_eq("basic_rise", 32'(cnt16), 32'(k));
            clk_m = 1'b0;
            #1;
            check_eq("basic_fall", 32'(cnt16), 32'(k));
        end

        // Asynchronous clear with clock static, then 5 edges still in reset.
        rst_n = 1'b0;
        edges = 0;
        #0.3;
        check_all("async_clear");
        tick(5, 1.0);
        check_all("async_hold");
        rst_n = 1'b1;
        #1;

        // Reset mid-operation at 37 with a 3 ns pulse between edges.
        tick(37, 1.0);
        check_all("mid_37");
        rst_n = 1'b0;
        edges = 0;
        #0.3;
        check_all("mid_clear");
        #2.7;
        rst_n = 1'b1;
        #1;
        tick(1, 1.0);
        check_all("mid_restart");

        // Random run lengths with occasional short random-width clear pulses.
        for (int it = 0; it < 16; it++) begin
            n = $urandom_range(1, 300);
            tick(n, 1.0);
            check_all("rand_run");
            if ($urandom_range(0, 2) == 0) begin
                pw = $urandom_range(1, 4);
                rst_n = 1'b0;
                edges = 0;
                #0.2;
                check_all("rand_clear");
                #(pw);
                rst_n = 1'b1;
                #1;
                tick(1, 1.0);
                check_all("rand_restart");
            end
        end

        // WIDTH=8: 300 edges from reset gives 44.
        do_reset();
        tick(300, 1.0);
        check_eq("w8_300", 32'(cnt8), 32'd44);

        // WIDTH=4 wrap 15 -> 0.
        do_reset();
        tick(15, 1.0);
        check_eq("w4_at15", 32'(cnt4), 32'd15);
        tick(1, 1.0);
        check_eq("w4_wrap", 32'(cnt4), 32'd0);

        // WIDTH=16 wrap: 65535 -> 0 -> 1.
        do_reset();
        tick(65535, 0.5);
        check_eq("w16_max", 32'(cnt16), 32'hFFFF);
        tick(1, 1.0);
        check_eq("w16_wrap", 32'(cnt16), 32'd0);
        tick(1, 1.0);
        check_eq("w16_after_wrap", 32'(cnt16), 32'd1);

        // Two clock domains on a shared clear: 10 ns vs 3.7 ns for 1000 ns.
        rst_n = 1'b0;
        edges = 0;
        run_b = 1'b1;
        #2.3;
        rst_n = 1'b1;
        tick(100, 5.0);
        check_eq("dual_a", 32'(cnt16), 32'd100);
        check_eq("dual_b_range", 32'((cntb >= 16'd269) && (cntb <= 16'd271)), 32'd1);
        rst_n = 1'b0;
        #0.2;
        check_eq("dual_clear_a", 32'(cnt16), 32'd0);
        check_eq("dual_clear_b", 32'(cntb), 32'd0);
        run_b = 1'b0;
        #5;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
